// File: rtl/bmp_ram_writer_pkg.sv
// Shared widths, BMP format constants and FSM encoding for the BMP RAM writer.
package bmp_ram_writer_pkg;

    localparam int unsigned BMP_ADDR_WIDTH  = 20;
    localparam int unsigned BMP_BYTE_WIDTH  = 8;
    localparam int unsigned BMP_TOTAL_SIZE  = 786486;

    localparam logic [7:0]  SIG_BYTE0       = 8'h42;
    localparam logic [7:0]  SIG_BYTE1       = 8'h4D;

    localparam int unsigned HDR_FIELD_BYTES = 4;
    localparam int unsigned FILE_SIZE_OFF   = 2;
    localparam int unsigned PIX_OFFSET_OFF  = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/bmp_ram_writer_ram.sv
// Single-write/single-read synchronous byte RAM with registered, read-before-write read port.
module bmp_ram
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned DEPTH      = 786486
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [BYTE_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [BYTE_WIDTH-1:0] rdata_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BYTE_WIDTH-1:0] mem [DEPTH];
    logic [BYTE_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      widx;
    logic [IDX_W-1:0]      ridx;

    assign widx    = IDX_W'(waddr_i);
    assign ridx    = IDX_W'(raddr_i);
    assign rdata_o = rdata_q;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[widx] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[ridx];
        end
    end

endmodule

// File: rtl/bmp_ram_writer.sv
// BMP byte-stream sink: validates signature/length, captures header fields, stores the file in RAM.
module bmp_ram_writer
    import bmp_ram_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BMP_ADDR_WIDTH,
    parameter int unsigned BYTE_WIDTH = BMP_BYTE_WIDTH,
    parameter int unsigned TOTAL_SIZE = BMP_TOTAL_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  RAM_ren,
    input  logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic [BYTE_WIDTH-1:0] RAM_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] bytes_written,
    output logic [31:0]           file_size,
    output logic [31:0]           pix_offset
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]           fs_q, fs_d;
    logic [31:0]           po_q, po_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept_c;
    logic                  last_addr_c;
    logic                  bad_sig_c;
    logic                  fs_hit_c, po_hit_c;
    logic [1:0]            fs_sel_c, po_sel_c;

    // ready_q is only ever high in WRITE, so it doubles as the write qualifier.
    assign accept_c    = ready_q && in_valid;
    assign last_addr_c = (cnt_q == ADDR_WIDTH'(TOTAL_SIZE - 1));
    assign bad_sig_c   = ((cnt_q == '0) && (in_data != BYTE_WIDTH'(SIG_BYTE0))) ||
                         ((cnt_q == ADDR_WIDTH'(1)) && (in_data != BYTE_WIDTH'(SIG_BYTE1)));

    assign fs_hit_c = (cnt_q >= ADDR_WIDTH'(FILE_SIZE_OFF)) &&
                      (cnt_q <  ADDR_WIDTH'(FILE_SIZE_OFF + HDR_FIELD_BYTES));
    assign po_hit_c = (cnt_q >= ADDR_WIDTH'(PIX_OFFSET_OFF)) &&
                      (cnt_q <  ADDR_WIDTH'(PIX_OFFSET_OFF + HDR_FIELD_BYTES));
    assign fs_sel_c = 2'(cnt_q - ADDR_WIDTH'(FILE_SIZE_OFF));
    assign po_sel_c = 2'(cnt_q - ADDR_WIDTH'(PIX_OFFSET_OFF));

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fs_q    <= '0;
            po_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fs_q    <= fs_d;
            po_q    <= po_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; signature failure takes priority over length checks.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (accept_c) begin
                    if (bad_sig_c) begin
                        state_d = S_ERR;
                    end else if (last_addr_c) begin
                        state_d = in_last ? S_DONE : S_ERR;
                    end else if (in_last) begin
                        state_d = S_ERR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        cnt_d   = cnt_q;
        fs_d    = fs_q;
        po_d    = po_q;
        ready_d = (state_d == S_WRITE);
        busy_d  = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
        if ((state_q != S_WRITE) && start) begin
            cnt_d = '0;
            fs_d  = '0;
            po_d  = '0;
        end else if (accept_c) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (fs_hit_c) begin
                fs_d[{fs_sel_c, 3'b000} +: 8] = 8'(in_data);
            end
            if (po_hit_c) begin
                po_d[{po_sel_c, 3'b000} +: 8] = 8'(in_data);
            end
        end
    end

    bmp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .DEPTH      (TOTAL_SIZE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept_c),
        .waddr_i (cnt_q),
        .wdata_i (in_data),
        .re_i    (RAM_ren),
        .raddr_i (RAM_addr),
        .rdata_o (RAM_out)
    );

    assign in_ready      = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign bytes_written = cnt_q;
    assign file_size     = fs_q;
    assign pix_offset    = po_q;

endmodule

// File: tb/tb_bmp_ram_writer.sv
// Scoreboard bench for bmp_ram_writer using a reduced 120-byte image.
module tb_bmp_ram_writer;

    localparam int unsigned AW = 20;
    localparam int unsigned BW = 8;
    localparam int unsigned TS = 120;

    typedef enum int {K_READY, K_BUSY, K_DONE, K_ERR, K_BYTES, K_FS, K_PO, K_RAMOUT} kind_t;
    typedef struct {
        kind_t       k;
        logic [31:0] exp;
    } chk_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          RAM_ren;
    logic [AW-1:0] RAM_addr;
    logic [BW-1:0] RAM_out;
    logic          busy, done, err;
    logic [AW-1:0] bytes_written;
    logic [31:0]   file_size, pix_offset;

    chk_t       st_q[$];
    logic [7:0] rd_q[$];
    logic       ren_seen = 1'b0;
    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] img  [TS];
    logic [7:0] img2 [TS];

    bmp_ram_writer #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .TOTAL_SIZE(TS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .RAM_ren       (RAM_ren),
        .RAM_addr      (RAM_addr),
        .RAM_out       (RAM_out),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .bytes_written (bytes_written),
        .file_size     (file_size),
        .pix_offset    (pix_offset)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(kind_t k);
        case (k)
            K_READY: return 32'(in_ready);
            K_BUSY:  return 32'(busy);
            K_DONE:  return 32'(done);
            K_ERR:   return 32'(err);
            K_BYTES: return 32'(bytes_written);
            K_FS:    return file_size;
            K_PO:    return pix_offset;
            default: return 32'(RAM_out);
        endcase
    endfunction

    always @(posedge clk) ren_seen <= RAM_ren;

    // Monitor: pops read-data expectations on each completed read, and status expectations each cycle.
    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [7:0]  e;
        logic [31:0] a;
        if (ren_seen) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_miss++;
                $display("FAIL rd_unexpected got %0h with no expected value queued", RAM_out);
            end else begin
                e = rd_q.pop_front();
                if (RAM_out !== e) begin
                    n_miss++;
                    $display("FAIL RAM_out got %0h want %0h", RAM_out, e);
                end
            end
        end
        while (st_q.size() > 0) begin
            c = st_q.pop_front();
            a = actual(c.k);
            n_vec++;
            if (a !== c.exp) begin
                n_miss++;
                $display("FAIL %s got %0h want %0h", c.k.name(), a, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input kind_t k, input logic [31:0] v);
        chk_t c;
        c.k   = k;
        c.exp = v;
        st_q.push_back(c);
    endtask

    task automatic expect_status(input logic r, input logic b, input logic d,
                                 input logic e, input int unsigned n);
        expect_st(K_READY, 32'(r));
        expect_st(K_BUSY,  32'(b));
        expect_st(K_DONE,  32'(d));
        expect_st(K_ERR,   32'(e));
        expect_st(K_BYTES, 32'(n));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input bit gaps);
        int waited = 0;
        if (gaps && ($urandom_range(0, 9) < 3)) begin
            in_valid = 1'b0;
            tick();
            expect_st(K_READY, 32'd1);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout in_ready got 0 want 1");
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stream(input bit use2, input int n, input bit last_end, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send(use2 ? img2[i] : img[i], last_end && (i == n - 1), gaps);
        end
    endtask

    task automatic rd(input int unsigned addr, input logic [7:0] e);
        RAM_ren  = 1'b1;
        RAM_addr = AW'(addr);
        rd_q.push_back(e);
        tick();
        RAM_ren  = 1'b0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < int'(TS); i++) begin
            img[i] = 8'(i * 7 + 3);
        end
        img[0] = 8'h42; img[1] = 8'h4D;
        img[2] = 8'h78; img[3] = 8'h00; img[4] = 8'h00; img[5] = 8'h00;
        img[10] = 8'h36; img[11] = 8'h00; img[12] = 8'h00; img[13] = 8'h00;
        for (int i = 0; i < int'(TS); i++) begin
            img2[i] = (i >= 14) ? (img[i] ^ 8'hFF) : img[i];
        end

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        RAM_ren = 1'b0; RAM_addr = '0;
        tick(); tick();
        rst_n = 1'b1;
        expect_status(0, 0, 0, 0, 0);
        expect_st(K_FS, 0); expect_st(K_PO, 0); expect_st(K_RAMOUT, 0);
        tick();

        // Well-formed file, valid held high.
        pulse_start();
        expect_status(1, 1, 0, 0, 0);
        stream(0, TS, 1, 0);
        expect_status(0, 0, 1, 0, TS);
        expect_st(K_FS, 32'd120); expect_st(K_PO, 32'd54);
        rd(0, 8'h42); rd(1, 8'h4D); rd(TS - 1, img[TS - 1]);
        tick(); tick();
        expect_st(K_RAMOUT, 32'(img[TS - 1]));

        // Same file with idle gaps; fields clear on start.
        pulse_start();
        expect_st(K_FS, 0); expect_st(K_PO, 0);
        stream(0, TS, 1, 1);
        expect_status(0, 0, 1, 0, TS);
        for (int i = 0; i < int'(TS); i++) rd(i, img[i]);

        // Bad signature.
        pulse_start();
        in_valid = 1'b1; in_data = 8'h41; in_last = 1'b0;
        tick();
        expect_status(0, 0, 0, 1, 1);
        tick();
        expect_st(K_READY, 0); expect_st(K_BYTES, 1);
        in_valid = 1'b0;
        rd(0, 8'h41);

        // Short file.
        pulse_start();
        stream(0, 100, 1, 0);
        expect_status(0, 0, 0, 1, 100);
        expect_st(K_FS, 32'd120);

        // Long file: extra byte refused.
        pulse_start();
        stream(0, TS, 0, 0);
        expect_status(0, 0, 0, 1, TS);
        in_valid = 1'b1; in_data = 8'hEE;
        tick(); tick();
        expect_st(K_READY, 0); expect_st(K_BYTES, TS);
        in_valid = 1'b0;
        rd(TS - 1, img[TS - 1]);

        // Partial capture with read-before-write, ignored start, then reset.
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                RAM_ren = 1'b1; RAM_addr = AW'(20);
                rd_q.push_back(img[20]);
            end
            if (i == 30) start = 1'b1;
            send(img2[i], 1'b0, 1'b0);
            RAM_ren = 1'b0;
            start   = 1'b0;
            if (i == 30) expect_st(K_BYTES, 31);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_status(0, 0, 0, 0, 0);
        expect_st(K_FS, 0); expect_st(K_PO, 0); expect_st(K_RAMOUT, 0);
        tick();
        pulse_start();
        stream(1, TS, 1, 0);
        expect_status(0, 0, 1, 0, TS);
        expect_st(K_PO, 32'd54);
        rd(20, img2[20]); rd(60, img2[60]); rd(1, 8'h4D);

        guard = 0;
        while ((rd_q.size() != 0 || st_q.size() != 0) && guard < 10) begin
            tick();
            guard++;
        end
        tick(); tick();
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain got %0d pending want 0", rd_q.size() + st_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
